// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: register file, operand assembly with IMM-prefix
// extension, single-destination scoreboard with RAW/WAW stall and writeback bypass.
module alu_operand_stage #(
   parameter int unsigned BITS  = 16,
   parameter int unsigned NREGS = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_imm_prefix,
   input  logic [11:0]     in_imm12,
   input  logic [4:0]      in_alu_op,
   input  logic [3:0]      in_rd,
   input  logic [3:0]      in_rs,
   input  logic            in_use_imm,
   input  logic [3:0]      in_imm4,
   input  logic            in_wr,
   input  logic            wb_en,
   input  logic [3:0]      wb_reg,
   input  logic [BITS-1:0] wb_data,
   output logic [BITS-1:0] A,
   output logic [BITS-1:0] B,
   output logic [4:0]      aluOp,
   output logic            execute,
   output logic [3:0]      out_rd,
   output logic            out_wr
);

   localparam int unsigned REG_W    = 4;
   localparam int unsigned OP_W     = 5;
   localparam int unsigned IMM_HI_W = 12;

   // architectural state
   logic [BITS-1:0]     regs_q [NREGS];
   logic                pend_valid_q, pend_valid_d;
   logic [REG_W-1:0]    pend_reg_q, pend_reg_d;
   logic                imm_hi_valid_q, imm_hi_valid_d;
   logic [IMM_HI_W-1:0] imm_hi_q, imm_hi_d;

   // issue registers
   logic [BITS-1:0]     a_q, a_d;
   logic [BITS-1:0]     b_q, b_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic                exec_q, exec_d;
   logic [REG_W-1:0]    rd_q, rd_d;
   logic                wr_q, wr_d;

   // combinational helpers
   logic [BITS-1:0]     rd_a_c, rd_b_c, imm_c;
   logic                wb_hits_pend_c, raw_c, waw_c, stall_c;
   logic                accept_c, issue_c, wb_we_c;

   // Register read ports with same-cycle writeback bypass; r0 is hardwired to zero.
   always_comb begin
      rd_a_c = '0;
      rd_b_c = '0;
      if (in_rd != '0) begin
         rd_a_c = (wb_en && wb_reg == in_rd) ? wb_data : regs_q[in_rd];
      end
      if (in_rs != '0) begin
         rd_b_c = (wb_en && wb_reg == in_rs) ? wb_data : regs_q[in_rs];
      end
   end

   // Immediate: prefix-extended when a prefix is held, else zero-extended nibble.
   always_comb begin
      imm_c = BITS'(in_imm4);
      if (imm_hi_valid_q) begin
         imm_c = BITS'({imm_hi_q, in_imm4});
      end
   end

   // Scoreboard hazard check; a pending register is never r0, so r0 never stalls.
   always_comb begin
      wb_hits_pend_c = pend_valid_q && wb_en && (wb_reg == pend_reg_q);
      raw_c          = (pend_reg_q == in_rd) || (!in_use_imm && (pend_reg_q == in_rs));
      waw_c          = in_wr && (in_rd != '0);
      stall_c        = !in_imm_prefix && pend_valid_q && !wb_hits_pend_c && (raw_c || waw_c);
   end

   assign in_ready = !stall_c;
   assign accept_c = in_valid && in_ready;
   assign issue_c  = accept_c && !in_imm_prefix;
   assign wb_we_c  = wb_en && (wb_reg != '0);

   // Next-state for prefix holder, scoreboard and issue registers.
   always_comb begin
      pend_valid_d   = pend_valid_q;
      pend_reg_d     = pend_reg_q;
      imm_hi_valid_d = imm_hi_valid_q;
      imm_hi_d       = imm_hi_q;
      a_d            = a_q;
      b_d            = b_q;
      op_d           = op_q;
      rd_d           = rd_q;
      wr_d           = wr_q;
      exec_d         = 1'b0;

      if (accept_c && in_imm_prefix) begin
         imm_hi_d       = in_imm12;
         imm_hi_valid_d = 1'b1;
      end

      if (issue_c) begin
         exec_d         = 1'b1;
         a_d            = rd_a_c;
         b_d            = in_use_imm ? imm_c : rd_b_c;
         op_d           = in_alu_op;
         rd_d           = in_rd;
         wr_d           = in_wr;
         imm_hi_valid_d = 1'b0;
      end

      // A new destination set wins over a clear landing on the same edge.
      if (wb_hits_pend_c) begin
         pend_valid_d = 1'b0;
      end
      if (issue_c && in_wr && (in_rd != '0)) begin
         pend_valid_d = 1'b1;
         pend_reg_d   = in_rd;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_valid_q   <= 1'b0;
         pend_reg_q     <= '0;
         imm_hi_valid_q <= 1'b0;
         imm_hi_q       <= '0;
         a_q            <= '0;
         b_q            <= '0;
         op_q           <= '0;
         exec_q         <= 1'b0;
         rd_q           <= '0;
         wr_q           <= 1'b0;
      end else begin
         pend_valid_q   <= pend_valid_d;
         pend_reg_q     <= pend_reg_d;
         imm_hi_valid_q <= imm_hi_valid_d;
         imm_hi_q       <= imm_hi_d;
         a_q            <= a_d;
         b_q            <= b_d;
         op_q           <= op_d;
         exec_q         <= exec_d;
         rd_q           <= rd_d;
         wr_q           <= wr_d;
      end
   end

   // Register file storage.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
      end else if (wb_we_c) begin
         regs_q[wb_reg] <= wb_data;
      end
   end

   assign A       = a_q;
   assign B       = b_q;
   assign aluOp   = op_q;
   assign execute = exec_q;
   assign out_rd  = rd_q;
   assign out_wr  = wr_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model of the stage.
module tb_alu_operand_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        in_valid, in_ready, in_imm_prefix, in_use_imm, in_wr, wb_en;
   logic [11:0] in_imm12;
   logic [4:0]  in_alu_op;
   logic [3:0]  in_rd, in_rs, in_imm4, wb_reg;
   logic [15:0] wb_data;
   logic [15:0] A, B;
   logic [4:0]  aluOp;
   logic        execute, out_wr;
   logic [3:0]  out_rd;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   alu_operand_stage #(.BITS(16), .NREGS(16)) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm_prefix(in_imm_prefix),
      .in_imm12(in_imm12), .in_alu_op(in_alu_op), .in_rd(in_rd), .in_rs(in_rs),
      .in_use_imm(in_use_imm), .in_imm4(in_imm4), .in_wr(in_wr),
      .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
      .A(A), .B(B), .aluOp(aluOp), .execute(execute), .out_rd(out_rd), .out_wr(out_wr)
   );

   // Behavioural model of the stage
   logic [15:0] m_reg [16];
   bit          m_pv;
   logic [3:0]  m_pr;
   bit          m_hv;
   logic [11:0] m_hi;
   logic [15:0] m_A, m_B;
   logic [4:0]  m_op;
   bit          m_ex, m_wr, m_live = 1'b0;
   logic [3:0]  m_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_read(input logic [3:0] x);
      if (x == 4'd0) return 16'h0000;
      if (wb_en && wb_reg == x) return wb_data;
      return m_reg[x];
   endfunction

   function automatic bit m_ready();
      if (in_imm_prefix || !m_pv) return 1'b1;
      if (wb_en && wb_reg == m_pr) return 1'b1;
      return !((in_rd == m_pr) || (!in_use_imm && in_rs == m_pr) || (in_wr && in_rd != 4'd0));
   endfunction

   // One clock: check ready, advance model at the falling edge, compare outputs after the rise.
   task automatic tick();
      bit acc, clr;
      @(negedge CLK);
      if (m_live && !RST) chk("in_ready", in_ready, m_ready());
      if (RST) begin
         for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
         m_pv = 0; m_pr = 0; m_hv = 0; m_hi = 0;
         m_A = 0; m_B = 0; m_op = 0; m_ex = 0; m_rd = 0; m_wr = 0;
         m_live = 1'b1;
      end else begin
         acc = in_valid && m_ready();
         clr = m_pv && wb_en && (wb_reg == m_pr);
         m_ex = 1'b0;
         if (acc && in_imm_prefix) begin
            m_hi = in_imm12;
            m_hv = 1'b1;
         end else if (acc) begin
            m_ex = 1'b1;
            m_A  = m_read(in_rd);
            if (!in_use_imm)  m_B = m_read(in_rs);
            else if (m_hv)    m_B = {m_hi, in_imm4};
            else              m_B = {12'h000, in_imm4};
            m_op = in_alu_op;
            m_rd = in_rd;
            m_wr = in_wr;
            m_hv = 1'b0;
         end
         if (acc && !in_imm_prefix && in_wr && in_rd != 4'd0) begin
            m_pv = 1'b1;
            m_pr = in_rd;
         end else if (clr) begin
            m_pv = 1'b0;
         end
         if (wb_en && wb_reg != 4'd0) m_reg[wb_reg] = wb_data;
      end
      @(posedge CLK);
      #1;
      if (m_live) begin
         chk("execute", execute, m_ex);
         chk("A", A, m_A);
         chk("B", B, m_B);
         chk("aluOp", aluOp, m_op);
         chk("out_rd", out_rd, m_rd);
         chk("out_wr", out_wr, m_wr);
      end
   endtask

   task automatic idle();
      in_valid = 0; in_imm_prefix = 0; in_imm12 = 0; in_alu_op = 0; in_rd = 0; in_rs = 0;
      in_use_imm = 0; in_imm4 = 0; in_wr = 0; wb_en = 0; wb_reg = 0; wb_data = 0;
   endtask

   task automatic instr(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input bit use_imm, input logic [3:0] imm4, input bit wr);
      in_valid = 1; in_imm_prefix = 0; in_alu_op = op; in_rd = rd; in_rs = rs;
      in_use_imm = use_imm; in_imm4 = imm4; in_wr = wr;
   endtask

   task automatic wb(input logic [3:0] r, input logic [15:0] d);
      idle();
      wb_en = 1; wb_reg = r; wb_data = d;
      tick();
      idle();
   endtask

   initial begin
      idle();
      RST = 1;
      tick(); tick();
      chk("rst_execute", execute, 0);
      chk("rst_A", A, 16'h0000);
      RST = 0;

      // add r3,r3 after writing r3
      wb(4'd3, 16'h1234);
      instr(5'd1, 4'd3, 4'd3, 0, 4'd0, 1);
      tick();
      chk("add_exec", execute, 1);
      chk("add_A", A, 16'h1234);
      chk("add_B", B, 16'h1234);
      chk("add_op", aluOp, 5'd1);
      idle();
      tick();
      chk("add_exec_drop", execute, 0);
      wb(4'd3, 16'h0042);

      // prefix extension, then consumed
      in_valid = 1; in_imm_prefix = 1; in_imm12 = 12'hABC;
      tick();
      chk("prefix_noexec", execute, 0);
      instr(5'd2, 4'd1, 4'd0, 1, 4'h5, 1);
      tick();
      chk("prefix_B", B, 16'hABC5);
      instr(5'd2, 4'd5, 4'd0, 1, 4'h5, 0);
      tick();
      chk("consumed_B", B, 16'h0005);
      wb(4'd1, 16'h0001);

      // RAW stall released by the writeback it waits on
      instr(5'd1, 4'd2, 4'd3, 0, 4'd0, 1);
      tick();
      instr(5'd3, 4'd4, 4'd2, 0, 4'd0, 1);
      #1 chk("stall_ready", in_ready, 0);
      tick();
      chk("stall_noexec", execute, 0);
      tick();
      wb_en = 1; wb_reg = 4'd2; wb_data = 16'h00FF;
      #1 chk("release_ready", in_ready, 1);
      tick();
      chk("release_exec", execute, 1);
      chk("release_B", B, 16'h00FF);
      idle();

      // back-to-back compares on unrelated registers
      for (int i = 0; i < 4; i++) begin
         instr(5'd7, 4'(5 + i), 4'(10 + i), 0, 4'd0, 0);
         tick();
         chk("cmp_exec", execute, 1);
      end
      idle();
      wb(4'd4, 16'h0444);

      // r0 stays zero and never stalls
      wb(4'd0, 16'hFFFF);
      instr(5'd1, 4'd0, 4'd0, 1, 4'd3, 1);
      tick();
      chk("r0_A", A, 16'h0000);
      instr(5'd1, 4'd7, 4'd0, 0, 4'd0, 0);
      #1 chk("r0_ready", in_ready, 1);
      tick();
      chk("r0_exec", execute, 1);
      chk("r0_B", B, 16'h0000);

      // reset clears pending and the held prefix
      instr(5'd1, 4'd6, 4'd6, 0, 4'd0, 1);
      tick();
      idle();
      in_valid = 1; in_imm_prefix = 1; in_imm12 = 12'h123;
      tick();
      idle();
      RST = 1;
      tick();
      RST = 0;
      chk("rst2_exec", execute, 0);
      instr(5'd4, 4'd6, 4'd6, 1, 4'h9, 1);
      #1 chk("rst2_ready", in_ready, 1);
      tick();
      chk("rst2_B", B, 16'h0009);
      chk("rst2_exec1", execute, 1);
      idle();

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         RST           = ($urandom_range(0, 99) == 0);
         in_valid      = ($urandom_range(0, 9) < 7);
         in_imm_prefix = ($urandom_range(0, 7) == 0);
         in_imm12      = 12'($urandom);
         in_alu_op     = 5'($urandom);
         in_rd         = 4'($urandom_range(0, 7));
         in_rs         = 4'($urandom_range(0, 7));
         in_use_imm    = 1'($urandom);
         in_imm4       = 4'($urandom);
         in_wr         = ($urandom_range(0, 3) != 0);
         wb_en         = ($urandom_range(0, 9) < 4);
         wb_reg        = (m_pv && $urandom_range(0, 1) == 1) ? m_pr : 4'($urandom_range(0, 7));
         wb_data       = 16'($urandom);
         tick();
      end
      RST = 0;
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
